// File: rtl/multicore_bus_controller_if.sv
// Bus bundle between the coherence controller, the per-core L1 caches and RAM.
// master = controller side; slave = caches plus RAM side.
interface multicore_bus_controller_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS*WORD_W-1:0] iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*WORD_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] dload;
    logic [CPUS-1:0]        ccwrite;
    logic [CPUS-1:0]        ccwait;
    logic [CPUS-1:0]        ccinv;
    logic [CPUS*WORD_W-1:0] ccsnoopaddr;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite,
        input  ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite,
        output ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/multicore_bus_controller.sv
// Snoop-coherence bus controller: CPUS L1 caches share one RAM port.
// Ports: CLK, RST (sync, active-high), bus (multicore_bus_controller_if.master).
// Round-robin arbitration of ifetch / writeback / coherent read; block moves
// cache-to-cache (with RAM update) or memory-to-cache, BLKWORDS words each.
// Build option: define WB_PRIORITY_EN to let any writeback beat all reads.
module multicore_bus_controller #(
    parameter int CPUS     = 2,
    parameter int BLKWORDS = 2,
    parameter int WORD_W   = 32
) (
    input logic                        CLK,
    input logic                        RST,
    multicore_bus_controller_if.master bus
);
    localparam int GW  = $clog2(CPUS);
    localparam int WCW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
    localparam logic [1:0] ACCESS = 2'd2;

    typedef enum logic [2:0] {IDLE, IFETCH, WB, SNOOP, C2C, M2C} state_t;

    state_t         state;
    logic [GW-1:0]  g, s, dptr, iptr;
    logic [WCW-1:0] wcnt;

    logic              acc, last;
    logic [CPUS-1:0]   g_oh, flush, dreq;
    logic [GW-1:0]     dpick, ipick, sup;
    logic [WORD_W-1:0] iaddr_g, daddr_g, daddr_s, dstore_s;

    // First requester at or after ptr, wrapping modulo CPUS.
    function automatic logic [GW-1:0] rr_pick(
        input logic [CPUS-1:0] req,
        input logic [GW-1:0]   ptr
    );
        logic [GW-1:0] w;
        logic [GW-1:0] idx;
        w = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = GW'((int'(ptr) + k) % CPUS);
            if (req[idx]) w = idx;
        end
        return w;
    endfunction

    function automatic logic [GW-1:0] nxt(input logic [GW-1:0] v);
        return (v == GW'(CPUS - 1)) ? '0 : v + GW'(1);
    endfunction

    assign acc      = bus.ramstate == ACCESS;
    assign last     = wcnt == WCW'(BLKWORDS - 1);
    assign g_oh     = CPUS'(1) << g;
    // The requester's own dWEN never counts as a flush reply.
    assign flush    = bus.dWEN & ~g_oh;
    assign dreq     = bus.dREN | bus.dWEN;
    assign iaddr_g  = bus.iaddr[g*WORD_W +: WORD_W];
    assign daddr_g  = bus.daddr[g*WORD_W +: WORD_W];
    assign daddr_s  = bus.daddr[s*WORD_W +: WORD_W];
    assign dstore_s = bus.dstore[s*WORD_W +: WORD_W];
    assign ipick    = rr_pick(bus.iREN, iptr);
    assign sup      = rr_pick(flush, '0);

`ifdef WB_PRIORITY_EN
    assign dpick = (|bus.dWEN) ? rr_pick(bus.dWEN, dptr)
                               : rr_pick(bus.dREN, dptr);
`else
    assign dpick = rr_pick(dreq, dptr);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            g     <= '0;
            s     <= '0;
            dptr  <= '0;
            iptr  <= '0;
            wcnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wcnt <= '0;
                    if (|dreq) begin
                        g     <= dpick;
                        state <= bus.dWEN[dpick] ? WB : SNOOP;
                    end else if (|bus.iREN) begin
                        g     <= ipick;
                        state <= IFETCH;
                    end
                end
                IFETCH: begin
                    if (acc || !bus.iREN[g]) begin
                        state <= IDLE;
                        iptr  <= nxt(g);
                    end
                end
                WB: begin
                    if (acc) wcnt <= wcnt + WCW'(1);
                    if ((acc && last) || !bus.dWEN[g]) begin
                        state <= IDLE;
                        dptr  <= nxt(g);
                    end
                end
                SNOOP: begin
                    if (|flush) begin
                        s     <= sup;
                        state <= C2C;
                    end else begin
                        state <= M2C;
                    end
                end
                C2C, M2C: begin
                    if (acc) wcnt <= wcnt + WCW'(1);
                    if ((acc && last) || !bus.dREN[g]) begin
                        state <= IDLE;
                        dptr  <= nxt(g);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.iwait       = '1;
        bus.dwait       = '1;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.iload       = '0;
        bus.dload       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        unique case (state)
            IFETCH: begin
                bus.ramREN                     = 1'b1;
                bus.ramaddr                    = iaddr_g;
                bus.iload[g*WORD_W +: WORD_W]  = bus.ramload;
                if (acc) bus.iwait[g]          = 1'b0;
            end
            WB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = daddr_g;
                bus.ramstore = bus.dstore[g*WORD_W +: WORD_W];
                if (acc) bus.dwait[g] = 1'b0;
            end
            SNOOP: begin
                for (int j = 0; j < CPUS; j++) begin
                    if (j != int'(g)) begin
                        bus.ccwait[j] = 1'b1;
                        bus.ccinv[j]  = bus.ccwrite[g];
                        bus.ccsnoopaddr[j*WORD_W +: WORD_W] = daddr_g;
                    end
                end
            end
            C2C: begin
                bus.ccwait                    = ~g_oh;
                bus.dload[g*WORD_W +: WORD_W] = dstore_s;
                bus.ramWEN                    = 1'b1;
                bus.ramaddr                   = daddr_s;
                bus.ramstore                  = dstore_s;
                if (acc) begin
                    bus.dwait[g] = 1'b0;
                    bus.dwait[s] = 1'b0;
                end
            end
            M2C: begin
                bus.ramREN                    = 1'b1;
                bus.ramaddr                   = daddr_g;
                bus.dload[g*WORD_W +: WORD_W] = bus.ramload;
                if (acc) bus.dwait[g] = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicore_bus_controller.sv
// Directed table-driven bench for multicore_bus_controller, CPUS=4, BLKWORDS=2.
// Expectations follow the WB_PRIORITY_EN define of the build.
module tb_multicore_bus_controller;
    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;
    localparam logic [31:0] RAMLOAD = 32'h5A5A_0001;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    multicore_bus_controller_if #(.CPUS(4), .WORD_W(32)) bus ();

    multicore_bus_controller #(
        .CPUS(4), .BLKWORDS(2), .WORD_W(32)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    logic [31:0] IADDR  [4] = '{32'h100, 32'h180, 32'h200, 32'h280};
    logic [31:0] DADDR  [4] = '{32'h20, 32'h40, 32'h80, 32'hC0};
    logic [31:0] DSTORE [4] = '{32'h1111_0000, 32'h1111_0001,
                                32'h1111_0002, 32'hDEAD_BEEF};

    typedef struct {
        logic         rst;
        logic [3:0]   iren, dren, dwen, ccw;
        logic [1:0]   rs;
        logic [3:0]   iw, dw, ccwt, cci;
        logic         ren, wen;
        logic [31:0]  addr, store;
        logic [127:0] snp;
        int           ldsel;
        int           ldc;
        logic [31:0]  ld;
    } vec_t;

    vec_t vq[$];
    vec_t cur;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] snpbus(input int g, input logic [31:0] a);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 4; j++)
            if (j != g) r[j*32 +: 32] = a;
        return r;
    endfunction

    task automatic row(input logic r, input logic [3:0] ir, dr, dw, cw,
                       input logic [1:0] rs);
        cur = '{default: '0};
        cur.rst  = r;
        cur.iren = ir;
        cur.dren = dr;
        cur.dwen = dw;
        cur.ccw  = cw;
        cur.rs   = rs;
        cur.iw   = 4'hF;
        cur.dw   = 4'hF;
    endtask

    task automatic ram(input logic rn, wn, input logic [31:0] a, st);
        cur.ren   = rn;
        cur.wen   = wn;
        cur.addr  = a;
        cur.store = st;
    endtask

    task automatic waits(input logic [3:0] iw, dw);
        cur.iw = iw;
        cur.dw = dw;
    endtask

    task automatic cc(input logic [3:0] w, i, input logic [127:0] sa);
        cur.ccwt = w;
        cur.cci  = i;
        cur.snp  = sa;
    endtask

    task automatic ld(input int sel, c, input logic [31:0] v);
        cur.ldsel = sel;
        cur.ldc   = c;
        cur.ld    = v;
    endtask

    task automatic push();
        vq.push_back(cur);
    endtask

    task automatic drive(input logic [3:0] ir, dr, dw, cw, input logic [1:0] rs);
        bus.iREN     = ir;
        bus.dREN     = dr;
        bus.dWEN     = dw;
        bus.ccwrite  = cw;
        bus.ramstate = rs;
    endtask

    task automatic build();
        // reset held two cycles in the middle of a writeback
        row(0, 0, 0, 4'b0001, 0, FREE); push();
        row(0, 0, 0, 4'b0001, 0, BUSY); ram(0, 1, DADDR[0], DSTORE[0]); push();
        row(1, 0, 0, 4'b0001, 0, BUSY); ram(0, 1, DADDR[0], DSTORE[0]); push();
        row(1, 0, 0, 4'b0001, 0, FREE); push();
        row(0, 0, 0, 0, 0, FREE); push();
        // full two-word writeback by core 0
        row(0, 0, 0, 4'b0001, 0, FREE); push();
        row(0, 0, 0, 4'b0001, 0, ACC); ram(0, 1, DADDR[0], DSTORE[0]);
        waits(4'hF, 4'b1110); push();
        row(0, 0, 0, 4'b0001, 0, BUSY); ram(0, 1, DADDR[0], DSTORE[0]); push();
        row(0, 0, 0, 4'b0001, 0, ACC); ram(0, 1, DADDR[0], DSTORE[0]);
        waits(4'hF, 4'b1110); push();
        row(0, 0, 0, 0, 0, FREE); push();
        // instruction fetches: core 0 then core 2
        row(0, 4'b0101, 0, 0, 0, FREE); push();
        row(0, 4'b0101, 0, 0, 0, BUSY); ram(1, 0, IADDR[0], 0);
        ld(1, 0, RAMLOAD); push();
        row(0, 4'b0101, 0, 0, 0, ACC); ram(1, 0, IADDR[0], 0);
        waits(4'b1110, 4'hF); ld(1, 0, RAMLOAD); push();
        row(0, 4'b0101, 0, 0, 0, FREE); push();
        row(0, 4'b0101, 0, 0, 0, BUSY); ram(1, 0, IADDR[2], 0);
        ld(1, 2, RAMLOAD); push();
        row(0, 4'b0101, 0, 0, 0, ACC); ram(1, 0, IADDR[2], 0);
        waits(4'b1011, 4'hF); ld(1, 2, RAMLOAD); push();
        row(0, 0, 0, 0, 0, FREE); push();
        // core 1 read, no flush -> memory-to-cache, ERROR holds waits
        row(0, 0, 4'b0010, 0, 0, FREE); push();
        row(0, 0, 4'b0010, 0, 0, FREE); cc(4'b1101, 4'b0000, snpbus(1, DADDR[1])); push();
        row(0, 0, 4'b0010, 0, 0, BUSY); ram(1, 0, DADDR[1], 0); ld(2, 1, RAMLOAD); push();
        row(0, 0, 4'b0010, 0, 0, ACC); ram(1, 0, DADDR[1], 0); ld(2, 1, RAMLOAD);
        waits(4'hF, 4'b1101); push();
        row(0, 0, 4'b0010, 0, 0, ERR); ram(1, 0, DADDR[1], 0); ld(2, 1, RAMLOAD); push();
        row(0, 0, 4'b0010, 0, 0, ACC); ram(1, 0, DADDR[1], 0); ld(2, 1, RAMLOAD);
        waits(4'hF, 4'b1101); push();
        row(0, 0, 0, 0, 0, FREE); push();
        // core 0 read-for-write, core 3 flushes -> cache-to-cache
        row(0, 0, 4'b0001, 0, 4'b0001, FREE); push();
        row(0, 0, 4'b0001, 4'b1000, 4'b0001, FREE);
        cc(4'b1110, 4'b1110, snpbus(0, DADDR[0])); push();
        row(0, 0, 4'b0001, 4'b1000, 4'b0001, BUSY); cc(4'b1110, 0, 0);
        ram(0, 1, DADDR[3], DSTORE[3]); ld(2, 0, DSTORE[3]); push();
        for (int k = 0; k < 2; k++) begin
            row(0, 0, 4'b0001, 4'b1000, 4'b0001, ACC); cc(4'b1110, 0, 0);
            ram(0, 1, DADDR[3], DSTORE[3]); ld(2, 0, DSTORE[3]);
            waits(4'hF, 4'b0110); push();
        end
        row(0, 0, 0, 0, 0, FREE); push();
        // all cores reading: grants rotate 0,1,2,3,0
        row(1, 0, 0, 0, 0, FREE); push();
        for (int n = 0; n < 5; n++) begin
            int gi;
            logic [3:0] oh;
            gi = n % 4;
            oh = 4'b0001 << gi;
            row(0, 0, 4'hF, 0, 0, FREE); push();
            row(0, 0, 4'hF, 0, 0, FREE); cc(~oh, 0, snpbus(gi, DADDR[gi])); push();
            for (int k = 0; k < 2; k++) begin
                row(0, 0, 4'hF, 0, 0, ACC); ram(1, 0, DADDR[gi], 0);
                ld(2, gi, RAMLOAD); waits(4'hF, ~oh); push();
            end
        end
        // core 1 read vs core 2 writeback from dptr 0
        row(1, 0, 0, 0, 0, FREE); push();
        row(0, 0, 4'b0010, 4'b0100, 0, FREE); push();
`ifdef WB_PRIORITY_EN
        row(0, 0, 4'b0010, 4'b0100, 0, FREE); ram(0, 1, DADDR[2], DSTORE[2]); push();
        row(1, 0, 4'b0010, 4'b0100, 0, FREE); ram(0, 1, DADDR[2], DSTORE[2]); push();
`else
        row(0, 0, 4'b0010, 4'b0100, 0, FREE); cc(4'b1101, 0, snpbus(1, DADDR[1])); push();
        row(1, 0, 4'b0010, 4'b0100, 0, FREE); cc(4'b1101, 0, 0);
        ram(0, 1, DADDR[2], DSTORE[2]); ld(2, 1, DSTORE[2]); push();
`endif
        row(0, 0, 0, 0, 0, FREE); push();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            bus.iaddr[i*32 +: 32]  = IADDR[i];
            bus.daddr[i*32 +: 32]  = DADDR[i];
            bus.dstore[i*32 +: 32] = DSTORE[i];
        end
        bus.ramload = RAMLOAD;
        drive(0, 0, 0, 0, FREE);
        build();

        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset iwait", bus.iwait, 4'hF);
        chk("reset dwait", bus.dwait, 4'hF);
        chk("reset ramREN", bus.ramREN, 1'b0);
        chk("reset ramWEN", bus.ramWEN, 1'b0);
        chk("reset ccwait", bus.ccwait, 4'h0);

        foreach (vq[i]) begin
            @(negedge CLK);
            RST = vq[i].rst;
            drive(vq[i].iren, vq[i].dren, vq[i].dwen, vq[i].ccw, vq[i].rs);
            #1;
            chk($sformatf("r%0d iwait", i), bus.iwait, vq[i].iw);
            chk($sformatf("r%0d dwait", i), bus.dwait, vq[i].dw);
            chk($sformatf("r%0d ccwait", i), bus.ccwait, vq[i].ccwt);
            chk($sformatf("r%0d ccinv", i), bus.ccinv, vq[i].cci);
            chk($sformatf("r%0d snoopaddr", i), bus.ccsnoopaddr, vq[i].snp);
            chk($sformatf("r%0d ramREN", i), bus.ramREN, vq[i].ren);
            chk($sformatf("r%0d ramWEN", i), bus.ramWEN, vq[i].wen);
            chk($sformatf("r%0d ramaddr", i), bus.ramaddr, vq[i].addr);
            chk($sformatf("r%0d ramstore", i), bus.ramstore, vq[i].store);
            if (vq[i].ldsel == 1)
                chk($sformatf("r%0d iload", i),
                    bus.iload[vq[i].ldc*32 +: 32], vq[i].ld);
            if (vq[i].ldsel == 2)
                chk($sformatf("r%0d dload", i),
                    bus.dload[vq[i].ldc*32 +: 32], vq[i].ld);
        end

        // abort of a memory-to-cache fill discards the word count (dptr=0)
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 4'b0010, 0, 0, FREE);
        @(negedge CLK);
        #1;
        chk("abort snoop ccwait", bus.ccwait, 4'b1101);
        @(negedge CLK);
        drive(0, 4'b0010, 0, 0, ACC);
        #1;
        chk("abort first word dwait", bus.dwait, 4'b1101);
        @(negedge CLK);
        drive(0, 0, 0, 0, BUSY);
        #1;
        chk("abort still m2c", bus.ramREN, 1'b1);
        @(negedge CLK);
        drive(0, 0, 0, 0, FREE);
        #1;
        chk("abort back idle ramREN", bus.ramREN, 1'b0);
        chk("abort back idle dwait", bus.dwait, 4'hF);
        drive(0, 4'b0010, 0, 0, FREE);
        @(negedge CLK);
        #1;
        chk("refill snoop ccwait", bus.ccwait, 4'b1101);
        @(negedge CLK);
        drive(0, 4'b0010, 0, 0, ACC);
        #1;
        chk("refill word0 dwait", bus.dwait, 4'b1101);
        @(negedge CLK);
        drive(0, 4'b0010, 0, 0, BUSY);
        #1;
        chk("refill count restarted", bus.ramREN, 1'b1);
        @(negedge CLK);
        drive(0, 0, 0, 0, FREE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicore_bus_controller.md
Name: multicore_bus_controller

Overview:
- Parametrised memory-bus and snoop-coherence controller between CPUS private L1 caches and one shared RAM port.
- Arbitrates instruction fetches, data writebacks and coherent data reads with round-robin fairness.
- Broadcasts snoops and invalidates to every non-requesting cache.
- Moves BLKWORDS-word blocks either cache-to-cache (with simultaneous RAM update) or memory-to-cache.

Parameters:
- CPUS, 2, number of cores; legal range 2..8.
- BLKWORDS, 2, words per coherent block transfer; legal range 1..8.
- WORD_W, 32, data and address width.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock; reset is synchronous and active-high
- iREN  in  CPUS  instruction read request per core
- iaddr  in  CPUS*WORD_W  instruction address per core; core i occupies bits [i*WORD_W +: WORD_W] (same packing for all per-core buses)
- iwait  out  CPUS  instruction wait per core
- iload  out  CPUS*WORD_W  instruction data per core
- dREN  in  CPUS  data read (cache fill) request
- dWEN  in  CPUS  data write: writeback when requesting, flush when snooped
- daddr  in  CPUS*WORD_W  data address per core
- dstore  in  CPUS*WORD_W  data store per core
- dwait  out  CPUS  data wait per core
- dload  out  CPUS*WORD_W  data load per core
- ccwrite  in  CPUS  requester wants exclusive (read-for-write) access
- ccwait  out  CPUS  snoop in progress; a core with ccwait set must service the snoop
- ccinv  out  CPUS  invalidate snooped line
- ccsnoopaddr  out  CPUS*WORD_W  snoop address per core
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM state: FREE, BUSY, ACCESS, ERROR (ramstate_t)

Behaviour:
- States: IDLE, IFETCH, WB, SNOOP, C2C, M2C.
- Registered: state, grant index g, data round-robin pointer dptr, instruction round-robin pointer iptr, word counter wcnt (clog2(BLKWORDS) bits, minimum 1).

Reset:
- RST high at a clock edge sets state=IDLE, g=0, dptr=0, iptr=0, wcnt=0.
- Applies mid-transaction too; any open RAM access is abandoned.

Outputs:
- Combinational from state.
- Defaults in every state: iwait=dwait=all ones; ccwait=ccinv=0; all load, snoop and RAM outputs 0.

IDLE (one arbitration cycle; no RAM traffic):
- Data requests (dREN|dWEN) beat instruction requests.
- Data winner: first requesting core at or after dptr, wrapping modulo CPUS.
  - If it has dWEN set: go to WB.
  - Otherwise: go to SNOOP.
- Else instruction winner: first iREN at or after iptr; go to IFETCH.
- Winner latched into g; wcnt cleared.

IFETCH:
- ramREN=1, ramaddr=iaddr[g], iload[g]=ramload.
- iwait[g]=0 only when ramstate==ACCESS.
- On ACCESS, or if iREN[g] drops: go to IDLE, iptr=g+1 mod CPUS.

WB:
- ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
- dwait[g]=0 on ACCESS, and wcnt increments.
- Exit to IDLE, dptr=g+1, when ACCESS with wcnt==BLKWORDS-1, or when dWEN[g] drops.

SNOOP (exactly one cycle):
- For every core j != g: ccwait[j]=1, ccsnoopaddr[j]=daddr[g], ccinv[j]=ccwrite[g].
- Next state:
  - C2C if any j != g has dWEN[j] set; supplier s = lowest such index, latched.
  - M2C otherwise.

C2C:
- ccwait stays high on every non-g core.
- dload[g]=dstore[s]; ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s] (memory updated in the same transfer).
- On ACCESS: dwait[g]=dwait[s]=0 and wcnt increments.

M2C:
- ramREN=1, ramaddr=daddr[g], dload[g]=ramload.
- On ACCESS: dwait[g]=0 and wcnt increments.

C2C/M2C exit:
- Go to IDLE, dptr=g+1, when ACCESS with wcnt==BLKWORDS-1, or when dREN[g] drops (abort; counter discarded).

Boundaries:
- ramstate BUSY, FREE or ERROR holds all waits high and does not advance wcnt.
- Simultaneous requests from all cores are served in rotating order; no core waits more than CPUS data grants.
- A core's own dWEN is never treated as a flush response to its own snoop.

Optional Feature:
- WB_PRIORITY_EN defined: in IDLE any dWEN (round-robin among writers from dptr) beats all dREN.
- WB_PRIORITY_EN undefined: dREN and dWEN share one round-robin, regardless of request type.

Test Plan:
- CPUS=4; RST held 2 cycles mid-WB -> next cycle state IDLE; iwait/dwait=4'hF; ramWEN=0, ramREN=0.
- Cores 0 and 2 iREN, RAM gives ACCESS one cycle after request -> core 0 served at 0x100, then core 2 at 0x200; each iwait low for exactly one cycle.
- Core 1 dREN addr 0x40, ccwrite=0, no flush, BLKWORDS=2 -> SNOOP with ccwait=4'b1101, ccinv=0; M2C loads 2 words; dwait[1] low twice; then IDLE.
- Core 0 dREN, ccwrite=1, core 3 flushes dstore=0xDEADBEEF -> ccinv=4'b1110; C2C gives dload[0]=0xDEADBEEF, ramWEN=1, ramaddr=daddr[3].
- All four cores dREN continuously -> grants 0,1,2,3,0 in order.
- Core 1 dREN and core 2 dWEN simultaneously, dptr=0 -> WB_PRIORITY_EN defined: core 2 WB first; undefined: core 1 SNOOP first.
